unary_driver_9: RTL and testbench

UNARY_DRIVER_9 -- requirements
Module: unary_driver_9

---
 rtl/unary_pkg.sv | 24 ++
 rtl/unary_pulse_gen.sv | 50 +++++
 rtl/unary_driver_9.sv | 186 ++++++++++++++++++
 tb/tb_unary_driver_9.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/unary_pkg.sv
// ============================================================================
// unary_pkg -- shared state encoding and constants for the unary adder driver.
// Revision: 1.0
// ============================================================================
`default_nettype none

package unary_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_WRITE  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam int          SUM_W         = 5;
    localparam logic [3:0]  MAX_DIGIT     = 4'd9;
    localparam logic [1:0]  SETTLE_CYCLES = 2'd2;
    localparam logic [4:0]  WRITE_TIMEOUT = 5'd17;

endpackage

`default_nettype wire

// File: rtl/unary_pulse_gen.sv
// ============================================================================
// unary_pulse_gen -- loadable 4-bit down-counter emitting one pulse per count.
// Revision: 1.0
// ============================================================================
`default_nettype none

module unary_pulse_gen (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic       pulse,
    output logic       zero
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
    logic       pulse_q;
    logic       pulse_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end
        // The registered pulse tracks the count it will see next cycle, so it
        // lines up with the counter value rather than lagging it.
        pulse_d = (cnt_d != 4'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= 4'd0;
            pulse_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse = pulse_q;
    // Counter is empty once the current cycle completes.
    assign zero  = (cnt_d == 4'd0);

endmodule

`default_nettype wire

// File: rtl/unary_driver_9.sv
// ============================================================================
// unary_driver_9 -- sequences one unary add (read, settle, write) on an adder.
// Optional: define UNARY_DRV_TIMEOUT_EN to abort a WRITE phase that overruns.
// Revision: 1.0
// ============================================================================
`default_nettype none

module unary_driver_9
    import unary_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op_a,
    input  logic [3:0]       op_b,
    output logic             A,
    output logic             B,
    output logic             en,
    output logic             read_or_write,
    input  logic             dout,
    input  logic             C,
    output logic             busy,
    output logic             done,
    output logic [SUM_W-1:0] sum,
    output logic             carry,
    output logic             err
);

    state_t             state_q, state_d;
    logic [SUM_W-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;
    logic               err_q, err_d;
    logic [1:0]         settle_q, settle_d;
    logic [4:0]         w_q, w_d;
    logic               en_q, en_d;
    logic               rw_q, rw_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               load;
    logic               dec;
    logic               a_zero;
    logic               b_zero;
    logic [4:0]         w_inc;

    assign dec = (state_q == ST_READ);

    unary_pulse_gen u_gen_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (op_a),
        .dec      (dec),
        .pulse    (A),
        .zero     (a_zero)
    );

    unary_pulse_gen u_gen_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (op_b),
        .dec      (dec),
        .pulse    (B),
        .zero     (b_zero)
    );

    // w only distinguishes the first write cycle; holding it at the timeout
    // value keeps it from wrapping back to zero during a long drain.
    assign w_inc = (w_q == WRITE_TIMEOUT) ? w_q : (w_q + 5'd1);

    always_comb begin
        state_d  = state_q;
        sum_d    = sum_q;
        carry_d  = carry_q;
        err_d    = err_q;
        settle_d = settle_q;
        w_d      = w_q;
        load     = 1'b0;

        if ((state_q == ST_READ) || (state_q == ST_SETTLE) || (state_q == ST_WRITE)) begin
            if (C) begin
                carry_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sum_d   = '0;
                    carry_d = 1'b0;
                    err_d   = 1'b0;
                    if ((op_a > MAX_DIGIT) || (op_b > MAX_DIGIT)) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        load     = 1'b1;
                        settle_d = 2'd0;
                        w_d      = 5'd0;
                        state_d  = ((op_a == 4'd0) && (op_b == 4'd0)) ? ST_SETTLE : ST_READ;
                    end
                end
            end
            ST_READ: begin
                if (a_zero && b_zero) begin
                    settle_d = 2'd0;
                    state_d  = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_q == (SETTLE_CYCLES - 2'd1)) begin
                    w_d     = 5'd0;
                    state_d = ST_WRITE;
                end else begin
                    settle_d = settle_q + 2'd1;
                end
            end
            ST_WRITE: begin
                // The adder output lags by one cycle, so dout at w=0 is stale.
                if ((w_q != 5'd0) && !dout) begin
                    state_d = ST_DONE;
                end else begin
                    if ((w_q != 5'd0) && (sum_q != {SUM_W{1'b1}})) begin
                        sum_d = sum_q + 1'b1;
                    end
                    w_d = w_inc;
`ifdef UNARY_DRV_TIMEOUT_EN
                    if (w_q == (WRITE_TIMEOUT - 5'd1)) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end
`endif
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they align with it.
        en_d   = (state_d == ST_READ) || (state_d == ST_SETTLE) || (state_d == ST_WRITE);
        rw_d   = (state_d == ST_WRITE);
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            sum_q    <= '0;
            carry_q  <= 1'b0;
            err_q    <= 1'b0;
            settle_q <= 2'd0;
            w_q      <= 5'd0;
            en_q     <= 1'b0;
            rw_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sum_q    <= sum_d;
            carry_q  <= carry_d;
            err_q    <= err_d;
            settle_q <= settle_d;
            w_q      <= w_d;
            en_q     <= en_d;
            rw_q     <= rw_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign en            = en_q;
    assign read_or_write = rw_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign sum           = sum_q;
    assign carry         = carry_q;
    assign err           = err_q;

endmodule

`default_nettype wire

// File: tb/tb_unary_driver_9.sv
// ============================================================================
// tb_unary_driver_9 -- scoreboard bench with a behavioural unary adder model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_unary_driver_9;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] op_a;
    logic [3:0] op_b;
    logic       A;
    logic       B;
    logic       en;
    logic       read_or_write;
    logic       dout;
    logic       C;
    logic       busy;
    logic       done;
    logic [4:0] sum;
    logic       carry;
    logic       err;

    always #5 clk = ~clk;

    unary_driver_9 dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .op_a          (op_a),
        .op_b          (op_b),
        .A             (A),
        .B             (B),
        .en            (en),
        .read_or_write (read_or_write),
        .dout          (dout),
        .C             (C),
        .busy          (busy),
        .done          (done),
        .sum           (sum),
        .carry         (carry),
        .err           (err)
    );

    // Adder model: accumulates pulses in read phase, raises C while idle in
    // read phase with a total of ten or more, drains with one cycle latency.
    int   acc;
    logic dout_m;
    logic force_hi;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= 0;
            dout_m <= 1'b0;
        end else if (en && !read_or_write) begin
            acc    <= acc + int'(A) + int'(B);
            dout_m <= 1'b0;
        end else if (en && read_or_write) begin
            dout_m <= (acc > 0);
            if (acc > 0) acc <= acc - 1;
        end else begin
            dout_m <= 1'b0;
        end
    end

    assign dout = force_hi | dout_m;
    assign C    = en && !read_or_write && !A && !B && (acc >= 10);

    typedef struct {
        int sum;
        int carry;
        int err;
        int a_hi;
        int b_hi;
        int settle;
        int busy_c;
        int en_c;
    } exp_t;

    exp_t q[$];
    int   checks    = 0;
    int   errors    = 0;
    int   done_seen = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: per-operation activity counters, compared on each done pulse.
    int a_c, b_c, s_c, busy_c, en_c;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            a_c = 0; b_c = 0; s_c = 0; busy_c = 0; en_c = 0;
        end else begin
            if (busy) busy_c++;
            if (A)    a_c++;
            if (B)    b_c++;
            if (en)   en_c++;
            if (en && !read_or_write && !A && !B) s_c++;
            if (done) begin
                done_seen++;
                if (q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("sum",         int'(sum),   e.sum);
                    check("carry",       int'(carry), e.carry);
                    check("err",         int'(err),   e.err);
                    check("A_cycles",    a_c,         e.a_hi);
                    check("B_cycles",    b_c,         e.b_hi);
                    check("settle",      s_c,         e.settle);
                    check("busy_cycles", busy_c,      e.busy_c);
                    check("en_cycles",   en_c,        e.en_c);
                end
                a_c = 0; b_c = 0; s_c = 0; busy_c = 0; en_c = 0;
            end
        end
    end

    task automatic wait_done(input int prev, input int budget);
        for (int i = 0; i < budget && done_seen == prev; i++) @(posedge clk);
        if (done_seen == prev) check("done_timeout", 0, 1);
    endtask

    task automatic issue(input logic [3:0] a, input logic [3:0] b);
        @(posedge clk); #1;
        start = 1'b1; op_a = a; op_b = b;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run(input logic [3:0] a, input logic [3:0] b, input exp_t e);
        int prev;
        prev = done_seen;
        q.push_back(e);
        issue(a, b);
        wait_done(prev, 200);
    endtask

    initial begin
        int prev;
        rst_n = 1'b0; start = 1'b0; op_a = 4'd0; op_b = 4'd0; force_hi = 1'b0;
        #2;
        check("rst_sum",   int'(sum),   0);
        check("rst_ctrl",  int'({A, B, en, read_or_write}), 0);
        check("rst_flags", int'({busy, done, carry, err}), 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        // 3+4 with a start pulsed while busy that must be ignored
        prev = done_seen;
        q.push_back(exp_t'{7, 0, 0, 3, 4, 2, 16, 15});
        issue(4'd3, 4'd4);
        repeat (3) @(posedge clk);
        #1 start = 1'b1; op_a = 4'd9; op_b = 4'd9;
        @(posedge clk); #1 start = 1'b0;
        wait_done(prev, 200);
        repeat (4) @(posedge clk);
        #1 check("sum_held", int'(sum), 7);

        run(4'd5,  4'd5,  exp_t'{10, 1, 0, 5, 5, 2, 20, 19});
        repeat (3) @(posedge clk);
        #1 check("carry_held", int'(carry), 1);
        run(4'd0,  4'd0,  exp_t'{0,  0, 0, 0, 0, 2, 5,  4});
        run(4'd12, 4'd3,  exp_t'{0,  0, 1, 0, 0, 0, 1,  0});
        run(4'd3,  4'd10, exp_t'{0,  0, 1, 0, 0, 0, 1,  0});
        run(4'd9,  4'd9,  exp_t'{18, 1, 0, 9, 9, 2, 32, 31});

        // Reset in the middle of READ for 6+2, then a clean 1+1
        issue(4'd6, 4'd2);
        repeat (2) @(posedge clk);
        #2 check("pre_reset_A", int'(A), 1);
        rst_n = 1'b0;
        #1;
        check("reset_A",    int'(A),    0);
        check("reset_B",    int'(B),    0);
        check("reset_en",   int'(en),   0);
        check("reset_busy", int'(busy), 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        run(4'd1, 4'd1, exp_t'{2, 0, 0, 1, 1, 2, 8, 7});

        // dout stuck high during WRITE
        force_hi = 1'b1;
`ifdef UNARY_DRV_TIMEOUT_EN
        run(4'd0, 4'd0, exp_t'{16, 0, 1, 0, 0, 2, 20, 19});
`else
        issue(4'd0, 4'd0);
        repeat (60) @(posedge clk);
        #1;
        check("stuck_busy",  int'(busy), 1);
        check("stuck_write", int'({en, read_or_write}), 3);
        check("stuck_sum",   int'(sum), 31);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
`endif
        force_hi = 1'b0;
        repeat (3) @(posedge clk);
        check("queue_drained", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
